// File: rtl/pc_stack16_pkg.sv
// Shared types and defaults for the program counter with return-address stack.
package pc_stack16_pkg;

    // One action per cycle, listed highest priority first.
    typedef enum logic [2:0] {
        OP_CLR,
        OP_CALL,
        OP_RET,
        OP_LOAD,
        OP_INC,
        OP_HOLD
    } pc_op_t;

    localparam int          DEF_WIDTH      = 16;
    localparam int          DEF_DEPTH      = 8;
    localparam logic [15:0] DEF_RESET_ADDR = 16'h0000;

endpackage

// File: rtl/pc_stack16_ras_lifo.sv
// Return-address LIFO: push/pop with count, full/empty decode and
// overflow/underflow strobes. A push when full or a pop when empty is
// dropped and only reported through the strobes. Push wins over pop.
module ras_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             do_push;
    logic             do_pop;

    // Write slot is the next free entry; the top entry sits one below it.
    // At count==DEPTH the low bits wrap to 0, so rd_addr still lands on DEPTH-1.
    assign wr_addr   = count[AW-1:0];
    assign rd_addr   = count[AW-1:0] - AW'(1);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !clr;
    assign do_pop    = pop && !push && !empty && !clr;
    assign overflow  = push && full && !clr;
    assign underflow = pop && !push && empty && !clr;
    assign dout      = mem[rd_addr];

    // Entry storage; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_stack16.sv
// 16-bit program counter with a hardware return-address stack and a sticky
// overflow/underflow error flag. All outputs come from registers.
module pc_stack16
    import pc_stack16_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    input  logic                     load,
    input  logic                     call,
    input  logic                     ret,
    input  logic [WIDTH-1:0]         load_val,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         pc_out,
    output logic [$clog2(DEPTH):0]   sp_out,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int CW = $clog2(DEPTH) + 1;

    pc_op_t           op;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] top_val;
    logic             overflow;
    logic             underflow;

    // Wraps FFFF -> 0000 silently; also the pushed return address.
    assign pc_plus1 = pc_out + WIDTH'(1);

    // Priority decode: clr > call > ret > load > inc > hold.
    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc) begin
            op = OP_INC;
        end
    end

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (op == OP_CLR),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .din       (pc_plus1),
        .dout      (top_val),
        .count     (sp_out),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // PC register; a rejected call or ret leaves the PC where it is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out <= RESET_ADDR;
        end else begin
            case (op)
                OP_CLR:  pc_out <= RESET_ADDR;
                OP_CALL: if (!full)  pc_out <= load_val;
                OP_RET:  if (!empty) pc_out <= top_val;
                OP_LOAD: pc_out <= load_val;
                OP_INC:  pc_out <= pc_plus1;
                default: pc_out <= pc_out;
            endcase
        end
    end

    // Sticky error: clr clears unconditionally, a new error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (op == OP_CLR) begin
            err <= 1'b0;
        end else if (overflow || underflow) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_stack16.sv
// Directed, table-driven bench for pc_stack16 plus hand sequences for reset.
module tb_pc_stack16;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic        clr;
        logic        inc;
        logic        load;
        logic        call;
        logic        ret;
        logic        err_clr;
        logic [15:0] load_val;
        logic [15:0] exp_pc;
        int          exp_sp;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        inc;
    logic        load;
    logic        call;
    logic        ret;
    logic [15:0] load_val;
    logic        err_clr;
    logic [15:0] pc_out;
    logic [3:0]  sp_out;
    logic        full;
    logic        empty;
    logic        err;

    int n_cmp;
    int n_bad;

    vec_t        vecs[$];
    logic [15:0] ras[DEPTH];

    pc_stack16 #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (inc),
        .load     (load),
        .call     (call),
        .ret      (ret),
        .load_val (load_val),
        .err_clr  (err_clr),
        .pc_out   (pc_out),
        .sp_out   (sp_out),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] e_pc, input int e_sp, input logic e_err);
        check({tag, " pc"},    pc_out,         e_pc);
        check({tag, " sp"},    16'(sp_out),    16'(e_sp));
        check({tag, " full"},  16'(full),      16'(e_sp == DEPTH));
        check({tag, " empty"}, 16'(empty),     16'(e_sp == 0));
        check({tag, " err"},   16'(err),       16'(e_err));
    endtask

    task automatic idle_inputs();
        clr = 0; inc = 0; load = 0; call = 0; ret = 0; err_clr = 0; load_val = '0;
    endtask

    function automatic vec_t mk(input logic c, input logic i, input logic l, input logic ca,
                                input logic r, input logic ec, input logic [15:0] lv,
                                input logic [15:0] pc, input int sp, input logic e);
        vec_t v;
        v.clr = c; v.inc = i; v.load = l; v.call = ca; v.ret = r; v.err_clr = ec;
        v.load_val = lv; v.exp_pc = pc; v.exp_sp = sp; v.exp_err = e;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clr = v.clr; inc = v.inc; load = v.load; call = v.call; ret = v.ret;
        err_clr = v.err_clr; load_val = v.load_val;
        @(posedge clk);
        #1;
        check_state($sformatf("vec%0d", idx), v.exp_pc, v.exp_sp, v.exp_err);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1;

        // Three increments, then async reset in the middle of a cycle.
        for (int k = 1; k <= 3; k++) begin
            apply(mk(0,1,0,0,0,0,16'h0, 16'(k), 0, 0), 100 + k);
        end
        @(negedge clk);
        inc = 1;
        #2;
        rst_n = 0;
        #1;
        check("async reset pc", pc_out, 16'h0000);
        check("async reset sp", 16'(sp_out), 16'h0000);
        @(posedge clk);
        #1;
        check("reset held pc", pc_out, 16'h0000);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;

        // Wrap, load, call/ret round trip, priority cases.
        vecs.push_back(mk(0,0,1,0,0,0,16'hFFFE, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0,1,0,0,0,0,16'h0000, 16'hFFFF, 0, 0));
        vecs.push_back(mk(0,1,0,0,0,0,16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0,16'h1234, 16'h0000, 0, 0));   // hold
        vecs.push_back(mk(0,1,1,0,0,0,16'h0010, 16'h0010, 0, 0));   // load beats inc
        vecs.push_back(mk(0,0,0,1,0,0,16'h0200, 16'h0200, 1, 0));
        vecs.push_back(mk(0,0,1,0,1,0,16'h0777, 16'h0011, 0, 0));   // ret beats load

        // Fill the stack: return address is the PC before the call, plus one.
        ras[0] = 16'h0012;
        for (int k = 0; k < DEPTH; k++) begin
            logic [15:0] tgt;
            tgt = 16'h1000 + 16'(k * 256);
            if (k > 0) ras[k] = 16'h1000 + 16'((k - 1) * 256) + 16'h0001;
            vecs.push_back(mk(0,0,0,1,0,0,tgt, tgt, k + 1, 0));
        end
        vecs.push_back(mk(0,0,0,1,0,0,16'h0ABC, 16'h1700, 8, 1));   // overflow
        for (int k = DEPTH - 1; k >= 0; k--) begin
            vecs.push_back(mk(0,0,0,0,1,0,16'h0000, ras[k], k, 1));
        end
        vecs.push_back(mk(0,0,0,0,1,0,16'h0000, 16'h0012, 0, 1));   // underflow

        // err_clr, call+ret+inc, underflow racing err_clr.
        vecs.push_back(mk(0,0,0,0,0,1,16'h0000, 16'h0012, 0, 0));
        vecs.push_back(mk(0,1,0,1,1,0,16'h0040, 16'h0040, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,16'h0000, 16'h0013, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,1,16'h0000, 16'h0013, 0, 1));
        vecs.push_back(mk(0,0,0,0,0,1,16'h0000, 16'h0013, 0, 0));

        // sp=3 with err=1, then clr+call.
        vecs.push_back(mk(0,0,0,0,1,0,16'h0000, 16'h0013, 0, 1));
        vecs.push_back(mk(0,0,0,1,0,0,16'h0100, 16'h0100, 1, 1));
        vecs.push_back(mk(0,0,0,1,0,0,16'h0200, 16'h0200, 2, 1));
        vecs.push_back(mk(0,0,0,1,0,0,16'h0300, 16'h0300, 3, 1));
        vecs.push_back(mk(1,1,1,1,1,0,16'h0400, 16'h0000, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,0,16'h0000, 16'h0000, 0, 1));   // nothing pushed

        // Return address wraps when calling from FFFF.
        vecs.push_back(mk(0,0,1,0,0,1,16'hFFFF, 16'hFFFF, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,0,16'h0123, 16'h0123, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,16'h0000, 16'h0000, 0, 0));

        foreach (vecs[k]) begin
            apply(vecs[k], k);
        end

        @(negedge clk);
        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack16.md
Name: pc_stack16

Overview:
- 16-bit program counter with a hardware return-address stack.
- Sits downstream of the 16-bit combinational gate library.
- Produces the instruction address consumed by instruction memory.
- Supports hold, increment, absolute load, call (push return address and jump), return (pop), and synchronous clear.
- Stack overflow and underflow are detected and reported through a sticky error flag.

Parameters:
- WIDTH, 16, address and data width of the PC and of each stack entry.
- DEPTH, 8, number of return-address stack entries; must be a power of two, minimum 2.
- RESET_ADDR, 16'h0000, PC value after async reset or `clr`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: PC to RESET_ADDR, stack emptied, err cleared.
- inc  input  1  PC <= PC+1.
- load  input  1  PC <= load_val.
- call  input  1  push PC+1, then PC <= load_val.
- ret  input  1  PC <= top of stack, pop.
- load_val  input  WIDTH  jump/call target.
- err_clr  input  1  clears the sticky err flag.
- pc_out  output  WIDTH  current program counter (registered).
- sp_out  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- full  output  1  sp_out == DEPTH.
- empty  output  1  sp_out == 0.
- err  output  1  sticky: a call was attempted when full, or a ret when empty.

Behaviour:
- Reset (rst_n=0, async): pc_out=RESET_ADDR, sp_out=0, empty=1, full=0, err=0. Stack RAM contents are not reset and are don't-care.
- All state updates on the rising clk edge. pc_out reflects a request issued in cycle N from cycle N+1 (1-cycle latency). full, empty and sp_out are combinational decodes of the registered SP.
- Per-cycle priority, highest first: clr > call > ret > load > inc > hold. Exactly one action takes effect per cycle; lower-priority requests asserted in the same cycle are ignored.
- clr:
  - pc <= RESET_ADDR; sp <= 0; err <= 0.
  - Overrides err_clr and any error in the same cycle.
- call, not full:
  - stack[sp] <= pc_out+1 (mod 2^WIDTH); sp <= sp+1; pc <= load_val.
- call, full:
  - No push, no jump, PC holds; err <= 1.
- ret, not empty:
  - pc <= stack[sp-1]; sp <= sp-1.
- ret, empty:
  - PC holds, sp stays 0; err <= 1.
- call and ret together:
  - call wins; ret is ignored and raises no error.
- load: pc <= load_val.
- inc: pc <= pc_out+1, wrapping 16'hFFFF -> 16'h0000 with no flag.
- Pushed return addresses wrap the same way: call at 16'hFFFF pushes 16'h0000.
- err:
  - Sticky; cleared only by err_clr or clr.
  - err_clr in the same cycle as a new error: err stays 1 (set wins).
- Reset mid-operation: async rst_n overrides everything immediately, without waiting for a clock edge. Release of rst_n is assumed synchronised externally.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - `pc_op_t` enum: OP_CLR, OP_CALL, OP_RET, OP_LOAD, OP_INC, OP_HOLD.
  - Default WIDTH/DEPTH constants.
  - RESET_ADDR constant.
- One natural sub-module: `ras_lifo`, a parameterised LIFO providing:
  - push/pop with data in/out;
  - count, full, empty;
  - overflow/underflow strobes.
- `pc_stack16` holds the priority decoder (an always_comb producing `pc_op_t`), the PC register, and the err flag.

Test Plan:
1. Reset then 3 cycles of inc -> pc_out 0,1,2,3; assert rst_n=0 mid-count -> pc_out=0 immediately, before the next clk edge.
2. load 16'hFFFE then inc ×2 -> pc_out 16'hFFFE, 16'hFFFF, 16'h0000; err stays 0.
3. pc_out=16'h0010, call load_val=16'h0200 -> pc_out=16'h0200, sp_out=1; then ret -> pc_out=16'h0011, sp_out=0, empty=1.
4. DEPTH=8: eight calls -> full=1, sp_out=8; a ninth call with load_val=16'h0ABC -> pc_out unchanged, err=1; eight rets return addresses in LIFO order; a ninth ret -> pc_out held, err still 1.
5. call+ret+inc asserted together, load_val=16'h0040 -> call executes (pc_out=16'h0040, sp_out+1), err=0. err_clr together with an underflowing ret -> err=1. err_clr alone on the next cycle -> err=0.
6. With sp_out=3 and err=1, assert clr together with call -> pc_out=RESET_ADDR, sp_out=0, err=0; no push occurs.
